// File: rtl/sha256d_header_ctrl.sv
// Double SHA-256 of an 80-byte header over one shared compression core, with a one-entry midstate cache.
// Latency from accept: 202 cycles on a cache miss, 135 on a hit.
// Backpressure: hdr_ready only in IDLE; the result is held in DONE until digest_ready.
module sha256d_header_ctrl #(
    parameter logic [255:0] IV          = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
    parameter bit           MIDSTATE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hdr_valid,
    output logic         hdr_ready,
    input  logic [639:0] header,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         core_start,
    output logic [511:0] core_chunk,
    output logic [255:0] core_state_in,
    input  logic [255:0] core_state_out,
    input  logic         core_finish
);

    typedef enum logic [2:0] {
        IDLE, C0_START, C0_WAIT, C1_START, C1_WAIT, C2_START, C2_WAIT, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [639:0]  hdr_q;
    logic [255:0]  mid_q;
    logic [511:0]  tag_q;
    logic          cache_vld;
    logic          hit;
    logic [511:0]  chunk_nxt;
    logic [255:0]  state_in_nxt;

    assign hit = MIDSTATE_EN && cache_vld && (header[639:128] == tag_q);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Chunk and chaining state are computed on the transition into each START
    // state, so the registered outputs are already stable in the START cycle.
    always_comb begin
        state_nxt    = state;
        hdr_ready    = 1'b0;
        digest_valid = 1'b0;
        chunk_nxt    = core_chunk;
        state_in_nxt = core_state_in;
        case (state)
            IDLE: begin
                hdr_ready = 1'b1;
                if (hdr_valid) begin
                    if (hit) begin
                        state_nxt    = C1_START;
                        chunk_nxt    = {header[127:0], 32'h80000000, 288'h0, 64'h280};
                        state_in_nxt = mid_q;
                    end else begin
                        state_nxt    = C0_START;
                        chunk_nxt    = header[639:128];
                        state_in_nxt = IV;
                    end
                end
            end
            C0_START: state_nxt = C0_WAIT;
            C0_WAIT: begin
                if (core_finish) begin
                    state_nxt    = C1_START;
                    chunk_nxt    = {hdr_q[127:0], 32'h80000000, 288'h0, 64'h280};
                    state_in_nxt = core_state_out;
                end
            end
            C1_START: state_nxt = C1_WAIT;
            C1_WAIT: begin
                if (core_finish) begin
                    state_nxt    = C2_START;
                    chunk_nxt    = {core_state_out, 32'h80000000, 160'h0, 64'h100};
                    state_in_nxt = IV;
                end
            end
            C2_START: state_nxt = C2_WAIT;
            C2_WAIT: begin
                if (core_finish) state_nxt = DONE;
            end
            DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_q         <= '0;
            mid_q         <= '0;
            tag_q         <= '0;
            cache_vld     <= 1'b0;
            digest        <= '0;
            core_chunk    <= '0;
            core_state_in <= '0;
            core_start    <= 1'b0;
        end else begin
            core_chunk    <= chunk_nxt;
            core_state_in <= state_in_nxt;
            core_start    <= (state_nxt == C0_START) || (state_nxt == C1_START) ||
                             (state_nxt == C2_START);
            if (state == IDLE && hdr_valid) hdr_q <= header;
            if (state == C0_WAIT && core_finish) begin
                mid_q     <= core_state_out;
                tag_q     <= hdr_q[639:128];
                cache_vld <= MIDSTATE_EN;
            end
            if (state == C2_WAIT && core_finish) digest <= core_state_out;
        end
    end

endmodule

// File: tb/tb_sha256d_header_ctrl.sv
// Bench for sha256d_header_ctrl: behavioural compression cores, scoreboard of expected digests/latencies.
module tb_sha256d_header_ctrl;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [2047:0] K_ALL = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [639:0] GENESIS = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
    localparam logic [255:0] GEN_DIG = 256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = st;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_ALL[2047-32*t -: 32] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
                st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
    endfunction

    function automatic logic [255:0] sha256d(input logic [639:0] hd);
        logic [255:0] m, d1;
        m  = sha_compress(IV, hd[639:128]);
        d1 = sha_compress(m, {hd[127:0], 32'h80000000, 288'h0, 64'h280});
        return sha_compress(IV, {d1, 32'h80000000, 160'h0, 64'h100});
    endfunction

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int           sel = 0;
    logic         hv = 1'b0;
    logic [639:0] hh = '0;
    logic         dr = 1'b1;

    logic         hdr_valid_w [2];
    logic         hdr_ready_w [2];
    logic         digest_valid_w [2];
    logic [255:0] digest_w [2];
    logic         core_start_w [2];
    logic [511:0] core_chunk_w [2];
    logic [255:0] core_state_in_w [2];
    logic [255:0] core_state_out_w [2];
    logic         core_finish_w [2];

    assign hdr_valid_w[0] = hv && (sel == 0);
    assign hdr_valid_w[1] = hv && (sel == 1);

    sha256d_header_ctrl #(.MIDSTATE_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .hdr_valid(hdr_valid_w[0]), .hdr_ready(hdr_ready_w[0]), .header(hh),
        .digest_valid(digest_valid_w[0]), .digest_ready(dr), .digest(digest_w[0]),
        .core_start(core_start_w[0]), .core_chunk(core_chunk_w[0]), .core_state_in(core_state_in_w[0]),
        .core_state_out(core_state_out_w[0]), .core_finish(core_finish_w[0]));

    sha256d_header_ctrl #(.MIDSTATE_EN(1'b0)) dut_nocache (
        .clk(clk), .reset(reset),
        .hdr_valid(hdr_valid_w[1]), .hdr_ready(hdr_ready_w[1]), .header(hh),
        .digest_valid(digest_valid_w[1]), .digest_ready(dr), .digest(digest_w[1]),
        .core_start(core_start_w[1]), .core_chunk(core_chunk_w[1]), .core_state_in(core_state_in_w[1]),
        .core_state_out(core_state_out_w[1]), .core_finish(core_finish_w[1]));

    // Core model: start sampled while idle, inputs latched one cycle later, finish 66 cycles after start.
    logic         busy [2];
    int           cnt [2];
    logic [255:0] cs_out [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                busy[i]   <= 1'b0;
                cnt[i]    <= 0;
                cs_out[i] <= '0;
            end else if (!busy[i]) begin
                if (core_start_w[i]) begin
                    busy[i] <= 1'b1;
                    cnt[i]  <= 1;
                end
            end else begin
                if (cnt[i] == 1) cs_out[i] <= sha_compress(core_state_in_w[i], core_chunk_w[i]);
                if (cnt[i] == 66) begin
                    busy[i] <= 1'b0;
                    cnt[i]  <= 0;
                end else begin
                    cnt[i] <= cnt[i] + 1;
                end
            end
        end
    end
    assign core_finish_w[0]    = busy[0] && (cnt[0] == 66);
    assign core_finish_w[1]    = busy[1] && (cnt[1] == 66);
    assign core_state_out_w[0] = cs_out[0];
    assign core_state_out_w[1] = cs_out[1];

    int cyc = 0;
    int start_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_start_w[sel]) start_cnt <= start_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [255:0] dig;
        int           lat;
        int           starts;
        int           acc_cyc;
        int           acc_st;
        string        name;
    } exp_t;
    exp_t sb [$];

    // Monitor: compare on the first cycle of each digest, then check it stays put while held.
    exp_t         e;
    logic         prev_vld = 1'b0;
    logic [255:0] held;
    always @(negedge clk) begin
        if (!reset && digest_valid_w[sel]) begin
            if (!prev_vld) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected digest: got %h, want none", digest_w[sel]);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " digest"}, digest_w[sel], e.dig);
                    check({e.name, " latency"}, 256'(cyc - e.acc_cyc), 256'(e.lat));
                    check({e.name, " starts"}, 256'(start_cnt - e.acc_st), 256'(e.starts));
                end
                held = digest_w[sel];
            end else begin
                check("digest hold", digest_w[sel], held);
            end
        end
        prev_vld = digest_valid_w[sel] && !reset;
    end

    task automatic submit(input logic [639:0] h, input logic [255:0] d, input int lat,
                          input int st, input string nm);
        exp_t x;
        int   k = 0;
        hv = 1'b1;
        hh = h;
        while (!hdr_ready_w[sel] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!hdr_ready_w[sel]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s accept timeout: got hdr_ready=0, want 1", nm);
            hv = 1'b0;
        end else begin
            x.dig = d; x.lat = lat; x.starts = st; x.acc_cyc = cyc; x.acc_st = start_cnt; x.name = nm;
            sb.push_back(x);
            @(negedge clk);
            hv = 1'b0;
        end
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while (sb.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s digest timeout: got %0d pending, want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    logic [639:0] hdr_n0, hdr_v2;
    int           snap;

    initial begin
        hdr_n0 = GENESIS;
        hdr_n0[31:0] = 32'h0;
        hdr_v2 = GENESIS;
        hdr_v2[639:632] = 8'h02;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst hdr_ready", 256'(hdr_ready_w[0]), 256'(1));
        check("rst digest_valid", 256'(digest_valid_w[0]), 256'(0));
        check("rst digest", digest_w[0], 256'h0);
        check("rst core_start", 256'(core_start_w[0]), 256'(0));
        check("rst core_chunk", core_chunk_w[0][511:256], 256'h0);
        check("rst core_state_in", core_state_in_w[0], 256'h0);
        reset = 1'b0;
        @(negedge clk);

        submit(GENESIS, GEN_DIG, 202, 3, "genesis miss");
        wait_drain("genesis miss");
        submit(GENESIS, GEN_DIG, 135, 2, "genesis hit");
        wait_drain("genesis hit");
        submit(hdr_n0, sha256d(hdr_n0), 135, 2, "nonce0 hit");
        wait_drain("nonce0 hit");
        submit(hdr_v2, sha256d(hdr_v2), 202, 3, "version2 miss");
        wait_drain("version2 miss");

        // Consumer stalls for 10 cycles while another header is offered.
        dr = 1'b0;
        submit(GENESIS, GEN_DIG, 202, 3, "stall first");
        wait_drain("stall first");
        hv = 1'b1;
        hh = GENESIS;
        snap = start_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall hdr_ready", 256'(hdr_ready_w[0]), 256'(0));
            check("stall digest_valid", 256'(digest_valid_w[0]), 256'(1));
            check("stall core_start", 256'(start_cnt), 256'(snap));
        end
        dr = 1'b1;
        submit(GENESIS, GEN_DIG, 135, 2, "after stall");
        wait_drain("after stall");

        // Reset in C1_WAIT of a hit; the cache must be gone afterwards.
        submit(GENESIS, GEN_DIG, 135, 2, "aborted");
        repeat (30) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        reset = 1'b0;
        check("post-rst digest_valid", 256'(digest_valid_w[0]), 256'(0));
        check("post-rst hdr_ready", 256'(hdr_ready_w[0]), 256'(1));
        submit(GENESIS, GEN_DIG, 202, 3, "post-rst miss");
        wait_drain("post-rst miss");

        sel = 1;
        @(negedge clk);
        submit(GENESIS, GEN_DIG, 202, 3, "nocache first");
        wait_drain("nocache first");
        submit(GENESIS, GEN_DIG, 202, 3, "nocache second");
        wait_drain("nocache second");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
